// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage initiator for the core's data memory.
// Takes one LOAD/STORE/PUSH/POP at a time over valid/ready, owns the stack
// pointer, drives registered strobes/address/data to the memory, captures
// read data one cycle after the strobe is sampled and returns a one-cycle
// response pulse with a fault flag.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   i_req_valid / o_req_ready     request handshake (ready only when idle)
//   i_op, i_en32, i_addr, i_wdata request: op (00 LD,01 ST,10 PUSH,11 POP),
//                                 32-bit pair select, address, write data
//   o_memRead, o_memWrite         registered memory strobes
//   o_en32, o_address, o_data     registered width, address, write data
//   i_mem_data                    memory read data (valid cycle after strobe)
//   o_resp_valid, o_rdata, o_error response pulse, load data, fault flag
//   o_sp                          current stack pointer
module mem_access_unit #(
  parameter logic [31:0] P_SP_RESET    = 32'h000FFFFF,
  parameter logic [31:0] P_STACK_LIMIT = 32'h000F0000,
  parameter logic [31:0] P_MEM_TOP     = 32'h000FFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_op,
  input  logic        i_en32,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_memRead,
  output logic        o_memWrite,
  output logic        o_en32,
  output logic [31:0] o_address,
  output logic [31:0] o_data,
  input  logic [31:0] i_mem_data,
  output logic        o_resp_valid,
  output logic [31:0] o_rdata,
  output logic        o_error,
  output logic [31:0] o_sp
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_FAULT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic        fault_q;
  logic        accept;
  logic        req_rd;
  logic [32:0] size;
  logic [32:0] sp_ext;
  logic [32:0] pop_sum;
  logic [31:0] acc_addr;
  logic        acc_fault;
  logic [31:0] sp_nxt;

  assign o_req_ready = (state == S_IDLE);
  assign accept      = i_req_valid && o_req_ready;
  assign req_rd      = (i_op == OP_LOAD) || (i_op == OP_POP);

  // Stack math is done 33 bits wide so limit checks never wrap.
  assign size    = i_en32 ? 33'd2 : 33'd1;
  assign sp_ext  = {1'b0, o_sp};
  assign pop_sum = sp_ext + size;

  always_comb begin
    acc_addr  = i_addr;
    acc_fault = 1'b0;
    sp_nxt    = o_sp;
    case (i_op)
      OP_LOAD, OP_STORE: begin
        acc_fault = (i_addr > P_MEM_TOP) || (i_en32 && (i_addr == 32'd0));
      end
      OP_PUSH: begin
        acc_addr  = o_sp;
        // SP - size + 1 < limit, rearranged to avoid underflow
        acc_fault = (sp_ext + 33'd1) < (size + {1'b0, P_STACK_LIMIT});
        sp_nxt    = o_sp - size[31:0];
      end
      default: begin // POP
        acc_addr  = pop_sum[31:0];
        acc_fault = pop_sum > {1'b0, P_SP_RESET};
        sp_nxt    = pop_sum[31:0];
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = acc_fault ? S_FAULT : S_ACCESS;
      S_ACCESS:  state_nxt = ((op_q == OP_LOAD) || (op_q == OP_POP)) ? S_CAPTURE : S_RESP;
      S_CAPTURE: state_nxt = S_RESP;
      S_FAULT:   state_nxt = S_RESP;
      S_RESP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      op_q         <= OP_LOAD;
      fault_q      <= 1'b0;
      o_memRead    <= 1'b0;
      o_memWrite   <= 1'b0;
      o_en32       <= 1'b0;
      o_address    <= '0;
      o_data       <= '0;
      o_resp_valid <= 1'b0;
      o_rdata      <= '0;
      o_error      <= 1'b0;
      o_sp         <= P_SP_RESET;
    end else begin
      state        <= state_nxt;
      // strobes and the response pulse are single-cycle by construction
      o_memRead    <= 1'b0;
      o_memWrite   <= 1'b0;
      o_resp_valid <= 1'b0;
      o_error      <= 1'b0;
      if (accept) begin
        op_q      <= i_op;
        fault_q   <= acc_fault;
        o_en32    <= i_en32;
        o_address <= acc_addr;
        o_data    <= i_wdata;
        if (!acc_fault) begin
          o_memRead  <= req_rd;
          o_memWrite <= !req_rd;
          o_sp       <= sp_nxt;
        end
      end
      // memory drives data only in CAPTURE; sampling elsewhere could latch Z
      if (state == S_CAPTURE) o_rdata <= i_mem_data;
      if (state_nxt == S_RESP) begin
        o_resp_valid <= 1'b1;
        o_error      <= fault_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam logic [31:0] SP_RESET    = 32'h000FFFFF;
  localparam logic [31:0] STACK_LIMIT = 32'h000F0000;
  localparam logic [31:0] MEM_TOP     = 32'h000FFFFF;
  localparam logic [1:0] LD = 2'b00, ST = 2'b01, PU = 2'b10, PO = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [1:0]  i_op = 2'b00;
  logic        i_en32 = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        o_memRead, o_memWrite, o_en32;
  logic [31:0] o_address, o_data;
  logic [31:0] i_mem_data = 32'hBAD0BAD0;
  logic        o_resp_valid;
  logic [31:0] o_rdata;
  logic        o_error;
  logic [31:0] o_sp;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_op(i_op), .i_en32(i_en32), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_memRead(o_memRead), .o_memWrite(o_memWrite), .o_en32(o_en32),
    .o_address(o_address), .o_data(o_data), .i_mem_data(i_mem_data),
    .o_resp_valid(o_resp_valid), .o_rdata(o_rdata), .o_error(o_error), .o_sp(o_sp)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory attached to the DUT (16-bit locations) ----------------
  logic [15:0] bmem [logic [31:0]];

  function automatic logic [15:0] brd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : 16'h0;
  endfunction

  always @(posedge clk) begin
    if (o_memWrite) begin
      if (o_en32) begin bmem[o_address - 1] = o_data[31:16]; bmem[o_address] = o_data[15:0]; end
      else bmem[o_address] = o_data[15:0];
    end
    // data only valid the cycle after the strobe; garbage otherwise
    if (o_memRead) i_mem_data <= o_en32 ? {brd(o_address - 1), brd(o_address)} : {16'h0, brd(o_address)};
    else           i_mem_data <= 32'hBAD0BAD0;
  end

  // ---------------- transaction-level model ----------------
  logic [15:0] mm [logic [31:0]];
  int          k = 0;        // cycles since accept, 0 = idle
  int          t_lat = 0;
  logic [1:0]  t_op = 2'b00;
  logic        t_en = 0, t_fault = 0;
  logic [31:0] t_addr = '0, t_data = '0, t_rdata = '0;
  logic [31:0] exp_sp = SP_RESET;
  logic [31:0] exp_rdata = '0;

  function automatic logic [15:0] mrd(input logic [31:0] a);
    return mm.exists(a) ? mm[a] : 16'h0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0; exp_sp = SP_RESET; exp_rdata = '0;
    end else if (k == 0) begin
      if (i_req_valid) begin
        longint sz, sp;
        sz = i_en32 ? 2 : 1;
        sp = exp_sp;
        t_op = i_op; t_en = i_en32; t_data = i_wdata;
        case (i_op)
          LD, ST: begin
            t_addr  = i_addr;
            t_fault = (i_addr > MEM_TOP) || (i_en32 && i_addr == 0);
          end
          PU: begin
            t_addr  = exp_sp;
            t_fault = (sp - sz + 1) < longint'(STACK_LIMIT);
            if (!t_fault) exp_sp = 32'(sp - sz);
          end
          default: begin
            t_addr  = 32'(sp + sz);
            t_fault = (sp + sz) > longint'(SP_RESET);
            if (!t_fault) exp_sp = 32'(sp + sz);
          end
        endcase
        if (!t_fault && (i_op == ST || i_op == PU)) begin
          if (i_en32) begin mm[t_addr - 1] = i_wdata[31:16]; mm[t_addr] = i_wdata[15:0]; end
          else mm[t_addr] = i_wdata[15:0];
        end
        t_rdata = i_en32 ? {mrd(t_addr - 1), mrd(t_addr)} : {16'h0, mrd(t_addr)};
        t_lat = t_fault ? 2 : ((i_op == LD || i_op == PO) ? 3 : 2);
        k = 1;
      end
    end else if (k == t_lat) begin
      k = 0;
    end else begin
      k++;
      if (k == t_lat && !t_fault && (t_op == LD || t_op == PO)) exp_rdata = t_rdata;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic rd, strobe;
      rd     = (t_op == LD) || (t_op == PO);
      strobe = (k == 1) && !t_fault;
      cmp("req_ready", 32'(o_req_ready), 32'(k == 0));
      cmp("resp_valid", 32'(o_resp_valid), 32'(k != 0 && k == t_lat));
      cmp("error", 32'(o_error), 32'(k != 0 && k == t_lat && t_fault));
      cmp("memRead", 32'(o_memRead), 32'(strobe && rd));
      cmp("memWrite", 32'(o_memWrite), 32'(strobe && !rd));
      if (strobe) begin
        cmp("address", o_address, t_addr);
        cmp("en32", 32'(o_en32), 32'(t_en));
        if (!rd) cmp("wdata", o_data, t_data);
      end
      cmp("sp", o_sp, exp_sp);
      cmp("rdata", o_rdata, exp_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    cmp("rst_sp", o_sp, SP_RESET);
    cmp("rst_memRead", 32'(o_memRead), 32'd0);
    cmp("rst_memWrite", 32'(o_memWrite), 32'd0);
    cmp("rst_ready", 32'(o_req_ready), 32'd1);
    cmp("rst_resp_valid", 32'(o_resp_valid), 32'd0);
    cmp("rst_rdata", o_rdata, 32'd0);
    cmp("rst_address", o_address, 32'd0);
    #1 rst = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic en, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat,
                       output logic [31:0] rdata, output logic err);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!o_req_ready && guard < 10) begin @(negedge clk); guard++; end
    i_req_valid = 1'b1; i_op = op; i_en32 = en; i_addr = addr; i_wdata = wdata;
    lat = 0; rdata = '0; err = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) i_req_valid = 1'b0;
      if (o_resp_valid) begin lat = n; rdata = o_rdata; err = o_error; break; end
    end
    if (lat == 0) begin
      n_chk++; n_fail++;
      $display("FAIL resp_timeout: no response within 8 cycles for op %0d", op);
    end
  endtask

  initial begin
    int lat;
    logic [31:0] rd;
    logic er;

    @(negedge clk);
    pulse_reset();
    chk_en = 1;

    issue(ST, 1, 32'h100, 32'hDEADBEEF, lat, rd, er);
    cmp("st32_lat", 32'(lat), 32'd2);
    cmp("st32_err", 32'(er), 32'd0);
    issue(LD, 1, 32'h100, 32'h0, lat, rd, er);
    cmp("ld32_lat", 32'(lat), 32'd3);
    cmp("ld32_data", rd, 32'hDEADBEEF);

    issue(PU, 0, 32'h0, 32'h00001234, lat, rd, er);
    cmp("push16_sp", o_sp, 32'h000FFFFE);
    issue(PU, 1, 32'h0, 32'hAABBCCDD, lat, rd, er);
    cmp("push32_sp", o_sp, 32'h000FFFFC);
    cmp("push32_lat", 32'(lat), 32'd2);
    issue(PO, 1, 32'h0, 32'h0, lat, rd, er);
    cmp("pop32_data", rd, 32'hAABBCCDD);
    cmp("pop32_sp", o_sp, 32'h000FFFFE);
    issue(PO, 0, 32'h0, 32'h0, lat, rd, er);
    cmp("pop16_data", rd, 32'h00001234);
    cmp("pop16_sp", o_sp, 32'h000FFFFF);

    issue(PO, 0, 32'h0, 32'h0, lat, rd, er);
    cmp("underflow_err", 32'(er), 32'd1);
    cmp("underflow_lat", 32'(lat), 32'd2);
    cmp("underflow_sp", o_sp, 32'h000FFFFF);

    issue(LD, 1, 32'h0, 32'h0, lat, rd, er);
    cmp("ld32_addr0_err", 32'(er), 32'd1);
    issue(LD, 0, 32'h00100000, 32'h0, lat, rd, er);
    cmp("ld16_oob_err", 32'(er), 32'd1);
    cmp("ld16_oob_rdata_held", rd, 32'h00001234);

    issue(ST, 0, 32'h0, 32'hFFFF5555, lat, rd, er);
    cmp("st16_addr0_err", 32'(er), 32'd0);
    issue(LD, 0, 32'h0, 32'h0, lat, rd, er);
    cmp("ld16_addr0_data", rd, 32'h00005555);
    issue(LD, 0, 32'h000FFFFF, 32'h0, lat, rd, er);
    cmp("ld16_top_data", rd, 32'h00001234);
    cmp("ld16_top_err", 32'(er), 32'd0);

    // reset while a STORE is in its strobe cycle
    @(negedge clk);
    i_req_valid = 1'b1; i_op = ST; i_en32 = 1'b1; i_addr = 32'h200; i_wdata = 32'h11112222;
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    cmp("mid_rst_strobe_before", 32'(o_memWrite), 32'd1);
    pulse_reset();
    repeat (3) @(negedge clk);

    issue(ST, 0, 32'h300, 32'h00000042, lat, rd, er);
    cmp("post_rst_st_lat", 32'(lat), 32'd2);
    issue(LD, 0, 32'h300, 32'h0, lat, rd, er);
    cmp("post_rst_ld_data", rd, 32'h00000042);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
